instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL be parametrised as follows:
- DATA_WIDTH, 8: width of the op-code, op1 and op2 fields; ir width is 3*DATA_WIDTH.
- ADDR_WIDTH, 8: program-counter width; must be <= DATA_WIDTH.
- STACK_DEPTH, 16: return-address stack entries; must be >= 2.
- IRQ_VECTOR, 1: program address loaded on interrupt entry.

REQ-002 The block SHALL have one clock; reset is synchronous and active-low.

REQ-003 The block SHALL have these ports (clock and reset first):
- clock  in  1  system clock.
- reset_s2_n  in  1  synchronous active-low reset.
- step_enable  in  1  state advances only on clock edges where this is 1.
- ir  in  3*DATA_WIDTH  instruction from program memory; valid in DECODE for the pc presented during FETCH.
- sr  in  4  datapath flags NZVC (sr[3]=N, sr[2]=Z).
- irq_req  in  1  level interrupt request.
- pc_out  out  ADDR_WIDTH  program counter.
- op_code, op1, op2  out  DATA_WIDTH each  decoded fields.
- exec_strobe  out  1  datapath executes op_code this cycle.
- irq_ack  out  1  interrupt accepted.
- sp_out  out  clog2(STACK_DEPTH+1)  stack entry count.
- halted  out  1  sequencer stopped on a stack fault.
- stack_overflow  out  1  sticky fault flag.
- stack_underflow  out  1  sticky fault flag.

Function
REQ-004 The FSM SHALL have states FETCH, DECODE, EXECUTE, IRQ and HALT; transitions occur only when step_enable=1, except that reset always applies.

REQ-005 FETCH SHALL go to IRQ if irq_req=1 and ie=1; otherwise it SHALL go to DECODE.

REQ-006 DECODE SHALL latch op_code=ir[3DW-1:2DW], op1=ir[2DW-1:DW] and op2=ir[DW-1:0], set pc=pc+1 modulo 2^ADDR_WIDTH, and go to EXECUTE.

REQ-007 In EXECUTE, exec_strobe SHALL be 1 for exactly that cycle (only when step_enable=1), the next state SHALL be FETCH, and the target SHALL be op1[ADDR_WIDTH-1:0].

REQ-008 EXECUTE SHALL decode these flow op-codes (hex):
- 20 JMP: pc=target.
- 21 BREQ: branch if Z=1.
- 22 BRNE: branch if Z=0.
- 23 BRGE: branch if N=0.
- 24 BRGT: branch if N=0 and Z=0.
- 25 BRLE: branch if N=1 or Z=1.
- 26 BRLT: branch if N=1.
- 27 CALL: push pc (already incremented), pc=target.
- 28 RET: pop into pc.
- 29 RETI: pop into pc, set ie=1.
- 2A EI: ie=1.
- 2B DI: ie=0.
All other op-codes SHALL leave pc as set in DECODE.

REQ-009 A not-taken branch SHALL leave pc=pc+1.

REQ-010 IRQ SHALL push pc, set pc=IRQ_VECTOR, clear ie, pulse irq_ack for one cycle, and go to FETCH.

REQ-011 IRQ SHALL NOT assert exec_strobe.

REQ-012 The stack SHALL be a LIFO of STACK_DEPTH entries of ADDR_WIDTH bits; a push writes entry[sp] then sp=sp+1, and a pop sets sp=sp-1 then reads entry[sp].

REQ-013 A push at sp=STACK_DEPTH (CALL or IRQ) SHALL NOT write, SHALL leave sp and pc unchanged, SHALL set stack_overflow, and SHALL go to HALT.

REQ-014 A pop at sp=0 (RET or RETI) SHALL leave pc unchanged, SHALL set stack_underflow, and SHALL go to HALT.

REQ-015 HALT SHALL be left only by reset; while halted, halted=1 and exec_strobe=0.

REQ-016 irq_req arriving in DECODE or EXECUTE SHALL be taken at the next FETCH, so interrupt latency is at most 3 enabled cycles.

REQ-017 An instruction SHALL never be interrupted mid-cycle.

REQ-018 With step_enable=0, all registers SHALL hold, and exec_strobe and irq_ack SHALL be 0.

Reset
REQ-019 On a clock edge with reset_s2_n=0, regardless of state or step_enable, the block SHALL set:
- state=FETCH.
- pc_out=0, op_code=0, op1=0, op2=0.
- sp_out=0 (stack contents don't-care).
- ie=0.
- exec_strobe=0, irq_ack=0.
- halted=0, stack_overflow=0, stack_underflow=0.

REQ-020 A reset asserted mid-instruction, including in IRQ or HALT, SHALL discard the instruction in progress, and the first FETCH after release SHALL present pc=0.

Verification
REQ-021 Straight-line program, step_enable=1 -> pc_out advances 0,1,2 once every 3 cycles, with exec_strobe 1 in cycles 2,5,8.

REQ-022 BREQ target 0x10 with Z=1, and again with Z=0 at pc=4 -> pc=0x10 when Z=1 and pc=5 when Z=0.

REQ-023 Repeat with BRGT/BRLT using sr=4'b1000, 4'b0000 and 4'b0100 -> the correct taken/not-taken outcome for each case.

REQ-024 CALL 0x20 at pc=3, then RET -> sp 0->1->0 and pc returns to 4.

REQ-025 Nested CALLs beyond depth -> the (STACK_DEPTH+1)th CALL sets stack_overflow=1 and halted=1, with pc frozen.

REQ-026 RET with sp=0 -> stack_underflow=1 and halted=1.

REQ-027 EI, then irq_req=1 during EXECUTE at pc=7 -> irq_ack pulses at the next FETCH, pc=IRQ_VECTOR, and ie=0; RETI then returns to pc=8 with ie=1.

REQ-028 Toggle step_enable 1010... -> the sequence is identical to REQ-021 but stretched 2x.

REQ-029 Reset asserted in EXECUTE of a CALL -> sp_out=0, pc_out=0, and state=FETCH on the next edge.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Three-phase fetch/decode/execute sequencer with flow-control op-codes,
// a return-address LIFO and one level-sensitive, maskable interrupt.
module instruction_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 16,
  parameter int IRQ_VECTOR  = 1
) (
  input  logic                             clock,
  input  logic                             reset_s2_n,
  input  logic                             step_enable,
  input  logic [3*DATA_WIDTH-1:0]          ir,
  input  logic [3:0]                       sr,
  input  logic                             irq_req,
  output logic [ADDR_WIDTH-1:0]            pc_out,
  output logic [DATA_WIDTH-1:0]            op_code,
  output logic [DATA_WIDTH-1:0]            op1,
  output logic [DATA_WIDTH-1:0]            op2,
  output logic                             exec_strobe,
  output logic                             irq_ack,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp_out,
  output logic                             halted,
  output logic                             stack_overflow,
  output logic                             stack_underflow
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W-1:0]       SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] IRQ_PC  = ADDR_WIDTH'(IRQ_VECTOR);

  localparam logic [DATA_WIDTH-1:0] OP_JMP  = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] OP_BREQ = DATA_WIDTH'(8'h21);
  localparam logic [DATA_WIDTH-1:0] OP_BRNE = DATA_WIDTH'(8'h22);
  localparam logic [DATA_WIDTH-1:0] OP_BRGE = DATA_WIDTH'(8'h23);
  localparam logic [DATA_WIDTH-1:0] OP_BRGT = DATA_WIDTH'(8'h24);
  localparam logic [DATA_WIDTH-1:0] OP_BRLE = DATA_WIDTH'(8'h25);
  localparam logic [DATA_WIDTH-1:0] OP_BRLT = DATA_WIDTH'(8'h26);
  localparam logic [DATA_WIDTH-1:0] OP_CALL = DATA_WIDTH'(8'h27);
  localparam logic [DATA_WIDTH-1:0] OP_RET  = DATA_WIDTH'(8'h28);
  localparam logic [DATA_WIDTH-1:0] OP_RETI = DATA_WIDTH'(8'h29);
  localparam logic [DATA_WIDTH-1:0] OP_EI   = DATA_WIDTH'(8'h2A);
  localparam logic [DATA_WIDTH-1:0] OP_DI   = DATA_WIDTH'(8'h2B);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_IRQ, S_HALT} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   op_code_q, op_code_d, op1_q, op1_d, op2_q, op2_d;
  logic [SP_W-1:0]         sp_q, sp_d;
  logic                    ie_q, ie_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d;

  logic [ADDR_WIDTH-1:0]   stack_mem [STACK_DEPTH];
  logic                    push_en;
  logic [IDX_W-1:0]        push_idx, pop_idx;
  logic [ADDR_WIDTH-1:0]   target;
  logic                    n_flag, z_flag;
  logic [1:0]              unused_sr;

  assign n_flag    = sr[3];
  assign z_flag    = sr[2];
  assign unused_sr = sr[1:0];
  assign target    = op1_q[ADDR_WIDTH-1:0];
  assign push_idx  = IDX_W'(sp_q);
  assign pop_idx   = IDX_W'(sp_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_code_d = op_code_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sp_d      = sp_q;
    ie_d      = ie_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;
    if (step_enable) begin
      case (state_q)
        S_FETCH: state_d = (irq_req && ie_q) ? S_IRQ : S_DECODE;
        S_DECODE: begin
          op_code_d = ir[3*DATA_WIDTH-1:2*DATA_WIDTH];
          op1_d     = ir[2*DATA_WIDTH-1:DATA_WIDTH];
          op2_d     = ir[DATA_WIDTH-1:0];
          pc_d      = pc_q + 1'b1;
          state_d   = S_EXECUTE;
        end
        S_EXECUTE: begin
          state_d = S_FETCH;
          case (op_code_q)
            OP_JMP:  pc_d = target;
            OP_BREQ: if (z_flag) pc_d = target;
            OP_BRNE: if (!z_flag) pc_d = target;
            OP_BRGE: if (!n_flag) pc_d = target;
            OP_BRGT: if (!n_flag && !z_flag) pc_d = target;
            OP_BRLE: if (n_flag || z_flag) pc_d = target;
            OP_BRLT: if (n_flag) pc_d = target;
            OP_CALL: begin
              if (sp_q == SP_FULL) begin
                ovf_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + 1'b1;
                pc_d    = target;
              end
            end
            OP_RET, OP_RETI: begin
              if (sp_q == '0) begin
                unf_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                sp_d = sp_q - 1'b1;
                pc_d = stack_mem[pop_idx];
                if (op_code_q == OP_RETI) ie_d = 1'b1;
              end
            end
            OP_EI:   ie_d = 1'b1;
            OP_DI:   ie_d = 1'b0;
            default: ;
          endcase
        end
        S_IRQ: begin
          // A full stack cannot save the return address, so the interrupt faults.
          if (sp_q == SP_FULL) begin
            ovf_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + 1'b1;
            pc_d    = IRQ_PC;
            ie_d    = 1'b0;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_s2_n) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      op_code_q <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      sp_q      <= '0;
      ie_q      <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_code_q <= op_code_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sp_q      <= sp_d;
      ie_q      <= ie_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Return addresses are always the already-advanced pc.
  always_ff @(posedge clock) begin
    if (reset_s2_n && push_en) stack_mem[push_idx] <= pc_q;
  end

  assign pc_out          = pc_q;
  assign op_code         = op_code_q;
  assign op1             = op1_q;
  assign op2             = op2_q;
  assign sp_out          = sp_q;
  assign halted          = (state_q == S_HALT);
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
  assign exec_strobe     = step_enable && (state_q == S_EXECUTE);
  assign irq_ack         = step_enable && (state_q == S_IRQ);
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: program memory model driven from
// pc_out, hand-computed expectations for flow control, stack and interrupts.
module tb_instruction_sequencer;
  logic        clock = 1'b0;
  logic        reset_s2_n;
  logic        step_enable;
  logic [23:0] ir;
  logic [3:0]  sr;
  logic        irq_req;
  logic [7:0]  pc_out, op_code, op1, op2;
  logic        exec_strobe, irq_ack, halted, stack_overflow, stack_underflow;
  logic [4:0]  sp_out;

  logic [23:0] prog [256];
  int n_checks = 0;
  int n_pass   = 0;

  instruction_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .STACK_DEPTH(16), .IRQ_VECTOR(1)
  ) dut (
    .clock(clock), .reset_s2_n(reset_s2_n), .step_enable(step_enable),
    .ir(ir), .sr(sr), .irq_req(irq_req), .pc_out(pc_out),
    .op_code(op_code), .op1(op1), .op2(op2), .exec_strobe(exec_strobe),
    .irq_ack(irq_ack), .sp_out(sp_out), .halted(halted),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;
  always_comb ir = prog[pc_out];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_instr();
    tick(); tick(); tick();
  endtask

  task automatic do_reset();
    reset_s2_n = 1'b0;
    tick(); tick();
    reset_s2_n = 1'b1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 24'h0;
  endtask

  function automatic logic [23:0] enc(input logic [7:0] op, input logic [7:0] tgt);
    return {op, tgt, 8'h00};
  endfunction

  int   pc_exp [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
  bit   es_exp [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  logic [7:0] br_op  [13] = '{8'h21, 8'h21, 8'h24, 8'h24, 8'h24, 8'h26, 8'h26,
                              8'h26, 8'h22, 8'h23, 8'h25, 8'h25, 8'h05};
  logic [3:0] br_sr  [13] = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b1000,
                              4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b0100};
  logic [7:0] br_exp [13] = '{8'h10, 8'h05, 8'h05, 8'h10, 8'h05, 8'h10, 8'h05,
                              8'h05, 8'h10, 8'h05, 8'h10, 8'h05, 8'h05};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_s2_n  = 1'b1;
    step_enable = 1'b0;
    sr          = 4'b0000;
    irq_req     = 1'b0;
    clear_prog();

    // Reset with step_enable low; then straight-line program.
    for (int i = 0; i < 8; i++) prog[i] = {8'(8'h01 + i), 8'(8'hA0 + i), 8'(8'h50 + i)};
    do_reset();
    check("rst_pc", pc_out, 0);
    check("rst_sp", sp_out, 0);
    check("rst_opcode", {op_code, op1, op2}, 0);
    check("rst_flags", {halted, stack_overflow, stack_underflow, irq_ack, exec_strobe}, 0);
    step_enable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      check($sformatf("line_pc_c%0d", c), pc_out, pc_exp[c]);
      check($sformatf("line_es_c%0d", c), exec_strobe, es_exp[c]);
      if (c % 3 == 2)
        check($sformatf("line_ir_c%0d", c), {op_code, op1, op2},
              {8'(8'h01 + c / 3), 8'(8'hA0 + c / 3), 8'(8'h50 + c / 3)});
      tick();
    end
    $display("txn straight-line: 3 instructions stepped");

    // Same program with step_enable toggling 1010...
    do_reset();
    for (int c = 0; c < 17; c++) begin
      step_enable = (c % 2 == 0);
      #1;
      check($sformatf("slow_pc_c%0d", c), pc_out, pc_exp[(c + 1) / 2]);
      check($sformatf("slow_es_c%0d", c), exec_strobe, (c % 2 == 0) ? es_exp[c / 2] : 1'b0);
      tick();
    end
    step_enable = 1'b1;
    $display("txn stretched: step_enable toggled");

    // Conditional branches at pc=4 with target 0x10.
    for (int k = 0; k < 13; k++) begin
      clear_prog();
      prog[0] = enc(8'h20, 8'h04);
      prog[4] = enc(br_op[k], 8'h10);
      sr = br_sr[k];
      do_reset();
      run_instr();
      check($sformatf("br%0d_jmp", k), pc_out, 8'h04);
      run_instr();
      check($sformatf("br%0d_op%0h_sr%0b", k, br_op[k], br_sr[k]), pc_out, br_exp[k]);
      $display("txn branch op=%0h sr=%4b pc=%0h", br_op[k], br_sr[k], pc_out);
    end
    sr = 4'b0000;

    // CALL 0x20 from pc=3, RET back to 4.
    clear_prog();
    prog[0]     = enc(8'h20, 8'h03);
    prog[3]     = enc(8'h27, 8'h20);
    prog[8'h20] = enc(8'h28, 8'h00);
    do_reset();
    run_instr();
    check("call_pre_pc", pc_out, 3);
    check("call_pre_sp", sp_out, 0);
    run_instr();
    check("call_pc", pc_out, 8'h20);
    check("call_sp", sp_out, 1);
    run_instr();
    check("ret_pc", pc_out, 4);
    check("ret_sp", sp_out, 0);
    $display("txn call/ret: pc=%0h sp=%0d", pc_out, sp_out);

    // Self-CALL until the stack overflows.
    clear_prog();
    prog[0] = enc(8'h27, 8'h00);
    do_reset();
    repeat (16) run_instr();
    check("ovf_full_sp", sp_out, 16);
    check("ovf_full_halt", {halted, stack_overflow}, 2'b00);
    run_instr();
    check("ovf_flags", {halted, stack_overflow, stack_underflow}, 3'b110);
    check("ovf_pc", pc_out, 1);
    check("ovf_sp", sp_out, 16);
    tick(); tick(); tick();
    check("ovf_hold_pc", pc_out, 1);
    check("ovf_hold_state", {halted, exec_strobe, irq_ack}, 3'b100);
    do_reset();
    check("ovf_reset_flags", {halted, stack_overflow, stack_underflow}, 3'b000);
    check("ovf_reset_pcsp", {pc_out, 3'b000, sp_out}, 16'h0000);
    $display("txn overflow: halted and recovered by reset");

    // RET on an empty stack.
    clear_prog();
    prog[0] = enc(8'h28, 8'h00);
    do_reset();
    run_instr();
    check("unf_flags", {halted, stack_overflow, stack_underflow}, 3'b101);
    check("unf_pc", pc_out, 1);
    check("unf_sp", sp_out, 0);
    $display("txn underflow: halted");

    // EI, interrupt during EXECUTE, ISR at vector 1 runs RETI.
    clear_prog();
    prog[0] = enc(8'h20, 8'h05);
    prog[1] = enc(8'h29, 8'h00);
    prog[5] = enc(8'h2A, 8'h00);
    do_reset();
    run_instr(); run_instr(); run_instr();
    check("irq_pre_pc", pc_out, 7);
    tick(); tick();
    check("irq_exec_es", exec_strobe, 1);
    irq_req = 1'b1;
    tick();
    check("irq_fetch_ack", irq_ack, 0);
    check("irq_fetch_pc", pc_out, 8);
    tick();
    check("irq_ack", irq_ack, 1);
    check("irq_no_es", exec_strobe, 0);
    tick();
    check("irq_vec_pc", pc_out, 1);
    check("irq_sp", sp_out, 1);
    check("irq_ack_clr", irq_ack, 0);
    tick();
    check("isr_masked", irq_ack, 0);
    tick();
    check("reti_es", exec_strobe, 1);
    tick();
    check("reti_pc", pc_out, 8);
    check("reti_sp", sp_out, 0);
    tick();
    check("reti_ie_set", irq_ack, 1);
    irq_req = 1'b0;
    $display("txn interrupt: vector taken and returned");

    // Reset during EXECUTE of a CALL.
    clear_prog();
    prog[0] = enc(8'h27, 8'h03);
    prog[3] = enc(8'h27, 8'h20);
    do_reset();
    run_instr();
    check("mid_pre_sp", sp_out, 1);
    tick(); tick();
    check("mid_exec_es", exec_strobe, 1);
    reset_s2_n = 1'b0;
    tick();
    check("mid_rst_pc", pc_out, 0);
    check("mid_rst_sp", sp_out, 0);
    check("mid_rst_es", exec_strobe, 0);
    reset_s2_n = 1'b1;
    run_instr();
    check("mid_refetch_pc", pc_out, 3);
    check("mid_refetch_sp", sp_out, 1);
    $display("txn reset mid-call: restarted at pc 0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
